mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access / writeback stage directly downstream of the integer ALU. Accepts one ALU result per handshake, and does one of three things with it: writes plain ALU results into the register file, issues loads and stores on a single-outstanding memory port, or sign/zero-extends load data before writing it back. Stalls upstream while a memory transaction is in flight.

## Interface
Parameters:
- XLEN, 64, datapath width
- ADDR_W, 64, memory address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept (high only in IDLE)
- in_data  input  XLEN  ALU result, or store data for stores
- in_addr  input  ADDR_W  effective address (loads/stores)
- in_rd  input  5  destination register
- in_is_load  input  1  load operation
- in_is_store  input  1  store operation
- in_size  input  2  0=byte, 1=half, 2=word, 3=double
- in_unsigned  input  1  zero-extend load
- mem_req  output  1  bus request, held until mem_gnt
- mem_we  output  1  1=write
- mem_addr  output  ADDR_W  address aligned to 8 bytes
- mem_wdata  output  XLEN  store data shifted to byte lane
- mem_wstrb  output  8  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  XLEN  read data (8-byte aligned)
- rf_we  output  1  register file write enable
- rf_waddr  output  5  register file write index
- rf_wdata  output  XLEN  register file write data
- trap  output  1  misaligned access (see Configuration)

## Operation
- States: IDLE, REQ, WAIT_RESP, WB.
- IDLE, in_valid, neither load nor store: register data and rd; rf_we=1 next cycle; remain in IDLE (one result per cycle throughput).
- IDLE, load or store: latch all inputs; go to REQ.
- REQ: mem_req=1 with stable address/data/strobes until mem_gnt.
  - Store: gnt -> IDLE.
  - Load: gnt without rvalid -> WAIT_RESP; gnt with rvalid in the same cycle -> WB, capturing rdata.
- WAIT_RESP: on rvalid, capture rdata -> WB.
- WB: rf_we=1 for one cycle with the extended load value -> IDLE.
- Writes to rd=0 are suppressed (rf_we stays 0).
- Lane placement uses off=addr[2:0].
  - mem_wdata = in_data << (8*off).
  - mem_wstrb = ((1<<(1<<size))-1) << off.
  - Load value = rdata >> (8*off), truncated to the size, then sign- or zero-extended to XLEN.
- mem_rvalid seen in IDLE or REQ-without-gnt is ignored.

## Timing
- Reset values: in_ready=1; mem_req, mem_we, rf_we and trap = 0; all data/address outputs = 0; state=IDLE.
- ALU result: accepted at edge N, rf_we high during cycle N+1.
- Store: mem_req rises at N+1; completion takes one cycle after gnt; in_ready returns the cycle after gnt.
- Load: rf write occurs the cycle after rvalid. Minimum load latency is 3 cycles (accept, REQ with gnt+rvalid, WB).
- Reset asserted mid-transaction drops mem_req immediately (asynchronous), discards the pending load, and returns to IDLE.
- in_ready is registered, derived from the state only; there is no combinational path from in_valid.

## Configuration
- MEM_MISALIGN_TRAP_EN
  - Defined: an access with addr not aligned to its size issues no bus request; trap pulses for one cycle, rf_we stays 0, and the FSM stays in IDLE.
  - Undefined: no alignment check; misaligned accesses that cross 8 bytes are truncated to the in-lane bytes; trap is tied to 0.

## Structure
- Shared package mem_pkg holds:
  - the state enum mem_state_t (IDLE, REQ, WAIT_RESP, WB);
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the strobe/mask helper function.
- Sub-module load_align: purely combinational shift, truncate and extend of rdata by off, size and unsigned.

## Test plan
- ALU result 0xDEAD_BEEF to rd=5 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF the next cycle; rd=0 -> no write.
- sb data 0xAB at addr 0x1003, gnt after 2 cycles -> mem_wstrb=0x08, mem_wdata[31:24]=0xAB, req held 3 cycles, in_ready low throughout.
- lb at 0x2001, rdata=0x0000_0000_0000_8000 -> rf_wdata=0xFFFF_FFFF_FFFF_FF80; lbu -> 0x80.
- lw with gnt and rvalid in the same cycle -> rf write exactly 1 cycle later; 3-cycle total latency.
- Reset pulse while in WAIT_RESP, then late rvalid -> mem_req=0, no rf write, in_ready=1.
- With MEM_MISALIGN_TRAP_EN: lw at 0x3002 -> trap=1 for 1 cycle, mem_req never asserted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the mem/wb stage.
// Holds the FSM state enum, access size enum and strobe/alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    WB
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } mem_size_t;

  localparam int LANES = 8;

  function automatic logic [LANES-1:0] size_bytes(
    input mem_size_t sz
  );
    logic [LANES-1:0] m;
    m = '0;
    unique case (sz)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0f;
      SZ_D: m = 8'hff;
    endcase
    return m;
  endfunction

  // bytes past lane 7 fall off the top
  function automatic logic [LANES-1:0] strb_mask(
    input mem_size_t sz,
    input logic [2:0] off
  );
    logic [LANES-1:0] m;
    m = size_bytes(sz);
    return m << off;
  endfunction

  function automatic logic [2:0] align_mask(
    input mem_size_t sz
  );
    logic [2:0] m;
    m = '0;
    unique case (sz)
      SZ_B: m = 3'd0;
      SZ_H: m = 3'd1;
      SZ_W: m = 3'd3;
      SZ_D: m = 3'd7;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input mem_size_t sz,
    input logic [2:0] off
  );
    return (off & align_mask(sz)) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data lane extraction: shift by byte offset,
// truncate to access size, then sign- or zero-extend.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  mem_size_t       size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;
  logic            sgn;

  // shift the addressed byte to lane 0 and extend
  always_comb begin
    sh   = rdata >> {off, 3'b000};
    sgn  = 1'b0;
    data = sh;
    unique case (size)
      SZ_B: begin
        sgn  = ~uns & sh[7];
        data = {{(XLEN-8){sgn}}, sh[7:0]};
      end
      SZ_H: begin
        sgn  = ~uns & sh[15];
        data = {{(XLEN-16){sgn}}, sh[15:0]};
      end
      SZ_W: begin
        sgn  = ~uns & sh[31];
        data = {{(XLEN-32){sgn}}, sh[31:0]};
      end
      SZ_D: begin
        data = sh;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage after the integer ALU.
// Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [4:0]        in_rd,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              trap
);

  mem_state_t state;
  mem_state_t state_n;

  logic ready_q;

  logic              we_q;
  logic              uns_q;
  mem_size_t         size_q;
  logic [2:0]        off_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [7:0]        wstrb_q;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;

  mem_size_t       size_in;
  logic            accept;
  logic            is_mem;
  logic            bad;
  logic            go_mem;
  logic            go_alu;
  logic            cap;
  logic [XLEN-1:0] ld_val;

  assign size_in = mem_size_t'(in_size);
  assign accept  = in_valid & (state == IDLE);
  assign is_mem  = in_is_load | in_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap_q;

  assign bad = misaligned(size_in, in_addr[2:0]);

  // one-cycle pulse for an access rejected as misaligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= accept & is_mem & bad;
    end
  end

  assign trap = trap_q;
`else
  assign bad  = 1'b0;
  assign trap = 1'b0;
`endif

  assign go_mem = accept & is_mem & ~bad;
  assign go_alu = accept & ~is_mem;

  assign cap = (state_n == WB) && (state != WB);

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (go_mem) state_n = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          if (we_q)            state_n = IDLE;
          else if (mem_rvalid) state_n = WB;
          else                 state_n = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) state_n = WB;
      end
      WB: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == IDLE);
    end
  end

  // latch the memory request so the bus sees stable values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      off_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (go_mem) begin
      we_q    <= in_is_store;
      uns_q   <= in_unsigned;
      size_q  <= size_in;
      off_q   <= in_addr[2:0];
      rd_q    <= in_rd;
      addr_q  <= {in_addr[ADDR_W-1:3], 3'b000};
      wdata_q <= in_data << {in_addr[2:0], 3'b000};
      wstrb_q <= strb_mask(size_in, in_addr[2:0]);
    end
  end

  load_align #(
    .XLEN (XLEN)
  ) u_align (
    .rdata (mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ld_val)
  );

  // register-file write port: ALU pass-through or aligned load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (go_alu) begin
        rf_we_q    <= (in_rd != 5'd0);
        rf_waddr_q <= in_rd;
        rf_wdata_q <= in_data;
      end else if (cap) begin
        rf_we_q    <= (rd_q != 5'd0);
        rf_waddr_q <= rd_q;
        rf_wdata_q <= ld_val;
      end
    end
  end

  assign in_ready  = ready_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = we_q & (state == REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage.
// Directed steps then random ops against a byte-level memory model.
module tb_mem_wb_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_addr;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        trap;

  int checks;
  int failures;

  logic [63:0] mem [logic [60:0]];

  mem_wb_stage #(
    .XLEN   (64),
    .ADDR_W (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .in_rd       (in_rd),
    .in_is_load  (in_is_load),
    .in_is_store (in_is_store),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rd_word(input logic [60:0] idx);
    if (mem.exists(idx)) return mem[idx];
    return {idx[31:0] * 32'h9E3779B1, ~idx[31:0]};
  endfunction

  // expected load value from the model memory, built byte by byte
  function automatic logic [63:0] exp_load(input logic [63:0] addr,
                                           input int n, input bit uns);
    logic [63:0] w;
    logic [63:0] v;
    int off;
    w = rd_word(addr[63:3]);
    off = int'(addr[2:0]);
    v = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz,
                       input bit uns, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] rd,
                       input int gd, input int rvd, input bit junk);
    int n;
    int off;
    bit trapm;
    logic [60:0] idx;
    logic [63:0] w;
    logic [63:0] exp_wd;
    logic [7:0] exp_st;
    n = 1 << sz;
    off = int'(addr[2:0]);
    idx = addr[63:3];
    trapm = TRAP_EN && ((off % n) != 0) && (ld || st);
    exp_st = 8'h00;
    for (int i = 0; i < n; i++)
      if (off + i < 8) exp_st[off+i] = 1'b1;
    exp_wd = data << (8 * off);

    chk("ready_before", in_ready, 1);
    in_valid = 1; in_is_load = ld; in_is_store = st;
    in_size = sz; in_unsigned = uns; in_addr = addr;
    in_data = data; in_rd = rd;
    step();
    in_valid = 0; in_is_load = 0; in_is_store = 0;

    if (!(ld || st)) begin
      chk("alu_we", rf_we, rd != 5'd0);
      if (rd != 5'd0) begin
        chk("alu_waddr", rf_waddr, rd);
        chk("alu_wdata", rf_wdata, data);
      end
      return;
    end

    if (trapm) begin
      chk("trap_pulse", trap, 1);
      chk("trap_noreq", mem_req, 0);
      chk("trap_nowe", rf_we, 0);
      chk("trap_ready", in_ready, 1);
      step();
      chk("trap_clear", trap, 0);
      chk("trap_noreq2", mem_req, 0);
      return;
    end

    chk("trap_low", trap, 0);
    for (int k = 0; k <= gd; k++) begin
      if (k == gd) begin
        mem_gnt = 1;
        if (ld && rvd == 0) begin
          mem_rvalid = 1; mem_rdata = rd_word(idx);
        end
      end else if (junk && ld) begin
        mem_rvalid = 1; mem_rdata = ~rd_word(idx);
      end
      chk("req_hi", mem_req, 1);
      chk("req_ready_lo", in_ready, 0);
      chk("req_we", mem_we, st);
      chk("req_addr", mem_addr, {addr[63:3], 3'b000});
      chk("req_rf_lo", rf_we, 0);
      if (st) begin
        chk("req_wstrb", mem_wstrb, exp_st);
        chk("req_wdata", mem_wdata, exp_wd);
      end
      step();
      mem_gnt = 0; mem_rvalid = 0;
    end

    if (st) begin
      chk("st_done_req", mem_req, 0);
      chk("st_done_ready", in_ready, 1);
      chk("st_done_rf", rf_we, 0);
      w = rd_word(idx);
      for (int i = 0; i < n; i++)
        if (off + i < 8) w[8*(off+i) +: 8] = data[8*i +: 8];
      mem[idx] = w;
      return;
    end

    if (rvd > 0) begin
      for (int k = 1; k < rvd; k++) begin
        chk("wait_req_lo", mem_req, 0);
        chk("wait_rf_lo", rf_we, 0);
        chk("wait_ready_lo", in_ready, 0);
        step();
      end
      chk("wait_rf_lo", rf_we, 0);
      mem_rvalid = 1; mem_rdata = rd_word(idx);
      step();
      mem_rvalid = 0;
    end

    chk("wb_we", rf_we, rd != 5'd0);
    if (rd != 5'd0) begin
      chk("wb_waddr", rf_waddr, rd);
      chk("wb_wdata", rf_wdata, exp_load(addr, n, uns));
    end
    chk("wb_ready_lo", in_ready, 0);
    step();
    chk("wb_done_we", rf_we, 0);
    chk("wb_done_ready", in_ready, 1);
  endtask

  initial begin
    int op;
    checks = 0; failures = 0;
    reset = 0; in_valid = 0; in_data = 0; in_addr = 0; in_rd = 0;
    in_is_load = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    step(); step();
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_trap", trap, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_rfwdata", rf_wdata, 0);
    reset = 1;
    step();

    do_op(0, 0, 2'd3, 0, 64'h0, 64'hDEAD_BEEF, 5'd5, 0, 0, 0);
    chk("alu_const", rf_wdata, 64'hDEAD_BEEF);
    do_op(0, 0, 2'd3, 0, 64'h0, 64'h1234, 5'd0, 0, 0, 0);
    do_op(0, 0, 2'd3, 0, 64'h0, 64'h55, 5'd9, 0, 0, 0);
    do_op(0, 0, 2'd3, 0, 64'h0, 64'h66, 5'd10, 0, 0, 0);

    do_op(0, 1, 2'd0, 0, 64'h1003, 64'hAB, 5'd0, 2, 0, 0);

    mem[61'h2000 >> 3] = 64'h0000_0000_0000_8000;
    do_op(1, 0, 2'd0, 0, 64'h2001, 64'h0, 5'd3, 1, 2, 1);
    chk("lb_const", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(1, 0, 2'd0, 1, 64'h2001, 64'h0, 5'd4, 0, 1, 0);
    chk("lbu_const", rf_wdata, 64'h80);
    do_op(1, 0, 2'd2, 0, 64'h2000, 64'h0, 5'd6, 0, 0, 0);
    do_op(1, 0, 2'd2, 0, 64'h3002, 64'h0, 5'd8, 0, 0, 0);

    in_valid = 1; in_is_load = 1; in_size = 2'd3;
    in_addr = 64'h2000; in_rd = 5'd7;
    step();
    in_valid = 0; in_is_load = 0;
    chk("rq_req_hi", mem_req, 1);
    #2 reset = 0;
    #1;
    chk("rq_async_req", mem_req, 0);
    chk("rq_async_ready", in_ready, 1);
    step();
    reset = 1;
    step();

    in_valid = 1; in_is_load = 1; in_size = 2'd3;
    in_addr = 64'h2000; in_rd = 5'd7;
    step();
    in_valid = 0; in_is_load = 0;
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("wr_req_lo", mem_req, 0);
    chk("wr_ready_lo", in_ready, 0);
    #2 reset = 0;
    #1;
    chk("wr_rst_ready", in_ready, 1);
    step();
    reset = 1;
    step();
    mem_rvalid = 1; mem_rdata = 64'h1111;
    step();
    mem_rvalid = 0;
    chk("late_rv_rf", rf_we, 0);
    chk("late_rv_req", mem_req, 0);
    chk("late_rv_ready", in_ready, 1);
    step();
    chk("late_rv_rf2", rf_we, 0);

    for (int t = 0; t < 300; t++) begin
      op = int'($urandom_range(0, 2));
      do_op(op == 1, op == 2, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            64'h4000 + 64'($urandom_range(0, 47)),
            {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
